// File: rtl/fitness_sequencer_if.sv
// Bus between the fitness sequencer and its controller/circuit harness.
// The slave modport is the sequencer side; the master modport is the controller side.
interface fitness_sequencer_if #(
  parameter int IN  = 4,
  parameter int OUT = 2
);
  localparam int TOTAL = OUT * (2 ** IN);
  localparam int FW    = $clog2(TOTAL + 1);

  logic                 start;
  logic [TOTAL-1:0]     target_tt;
  logic [IN-1:0]        circ_inp;
  logic [OUT-1:0]       circ_out;
  logic                 busy;
  logic                 done;
  logic [FW-1:0]        fitness;
  logic                 perfect;

  modport slave (
    input  start, target_tt, circ_out,
    output circ_inp, busy, done, fitness, perfect
  );

  modport master (
    output start, target_tt, circ_out,
    input  circ_inp, busy, done, fitness, perfect
  );
endinterface

// File: rtl/fitness_sequencer.sv
// Walks every input vector of a genetic circuit, scores matching output bits against a target truth table.
// Define GENETICO_OSC_CHECK_EN to add a second sample per vector that zeroes the score of oscillating outputs.
module fitness_sequencer #(
  parameter int IN     = 4,
  parameter int OUT    = 2,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fitness_sequencer_if.slave   bus
);
  localparam int TOTAL = OUT * (2 ** IN);
  localparam int FW    = $clog2(TOTAL + 1);
`ifdef GENETICO_OSC_CHECK_EN
  localparam int W = SETTLE + 1;
`else
  localparam int W = SETTLE;
`endif
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state;
  logic [CW-1:0]   cyc;
  logic [IN-1:0]   vec;
  logic            busy_r;
  logic            done_r;
  logic            perfect_r;
  logic [FW-1:0]   acc;
  logic [OUT-1:0]  tgt;
  logic [FW-1:0]   hits;
  logic [FW-1:0]   acc_nxt;

  function automatic logic [FW-1:0] popcount(input logic [OUT-1:0] x);
    logic [FW-1:0] n;
    n = '0;
    for (int i = 0; i < OUT; i++) n = n + FW'(x[i]);
    return n;
  endfunction

  assign tgt = bus.target_tt[vec*OUT +: OUT];

`ifdef GENETICO_OSC_CHECK_EN
  logic [OUT-1:0] early_s;

  // Early sample one cycle before the scoring sample; no reset needed, only read in RUN.
  always_ff @(posedge clk) begin
    if (state == RUN && cyc == CW'(W - 2)) early_s <= bus.circ_out;
  end
`endif

  always_comb begin
    hits = popcount(~(bus.circ_out ^ tgt));
`ifdef GENETICO_OSC_CHECK_EN
    if (early_s != bus.circ_out) hits = '0;
`endif
    acc_nxt = acc + hits;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      perfect_r <= 1'b0;
      acc       <= '0;
      vec       <= '0;
      cyc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RUN;
            busy_r    <= 1'b1;
            vec       <= '0;
            cyc       <= '0;
            acc       <= '0;
            perfect_r <= 1'b0;
          end
        end
        RUN: begin
          // Score on the last cycle of the window, then step straight to the next vector.
          if (cyc == CW'(W - 1)) begin
            acc <= acc_nxt;
            cyc <= '0;
            if (vec == '1) begin
              state     <= FINISH;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              perfect_r <= (acc_nxt == FW'(TOTAL));
            end else begin
              vec <= vec + IN'(1);
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        FINISH: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.circ_inp = vec;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.fitness  = acc;
  assign bus.perfect  = perfect_r;
endmodule

// File: tb/tb_fitness_sequencer.sv
// Scoreboard bench for fitness_sequencer: small (IN=2,OUT=1) and large (IN=4,OUT=2) instances.
module tb_fitness_sequencer;
`ifdef GENETICO_OSC_CHECK_EN
  localparam int W = 3;
`else
  localparam int W = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic osc_mode;
  logic tog = 1'b0;
  int   cyc_cnt = 0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    tog     <= ~tog;
  end

  fitness_sequencer_if #(.IN(2), .OUT(1)) bus1 ();
  fitness_sequencer_if #(.IN(4), .OUT(2)) bus4 ();

  // Bench circuits: XOR of the two inputs (optionally oscillating on vector 3), and an all-ones circuit.
  assign bus1.circ_out = (osc_mode && bus1.circ_inp == 2'd3) ? tog : (bus1.circ_inp[0] ^ bus1.circ_inp[1]);
  assign bus4.circ_out = 2'b11;

  fitness_sequencer #(.IN(2), .OUT(1), .SETTLE(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  fitness_sequencer #(.IN(4), .OUT(2), .SETTLE(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  typedef struct {
    int fit;
    int perf;
    int cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitors: compare every done pulse against the oldest expected result.
  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus1.done === 1'b1) begin
        if (q1.size() == 0) check("unexpected_done1", 1, 0);
        else begin
          e = q1.pop_front();
          check("fitness1", int'(bus1.fitness), e.fit);
          check("perfect1", int'(bus1.perfect), e.perf);
          check("done_cycle1", cyc_cnt, e.cyc);
          check("busy_at_done1", int'(bus1.busy), 0);
        end
      end
    end
  end

  initial begin : mon4
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus4.done === 1'b1) begin
        if (q4.size() == 0) check("unexpected_done4", 1, 0);
        else begin
          e = q4.pop_front();
          check("fitness4", int'(bus4.fitness), e.fit);
          check("perfect4", int'(bus4.perfect), e.perf);
          check("done_cycle4", cyc_cnt, e.cyc);
        end
      end
    end
  end

  // Caller is at cycle 0 (a negedge); issues start and walks the whole run.
  task automatic run1(input logic [3:0] tgt, input int fit, input int perf);
    exp_t e;
    bus1.target_tt = tgt;
    bus1.start     = 1'b1;
    e.fit = fit; e.perf = perf; e.cyc = cyc_cnt + 4*W + 1;
    q1.push_back(e);
    tick();
    bus1.start = 1'b0;
    for (int k = 1; k <= 4*W; k++) begin
      check("circ_inp_seq", int'(bus1.circ_inp), (k - 1) / W);
      check("busy_run", int'(bus1.busy), 1);
      tick();
    end
    check("busy_finish", int'(bus1.busy), 0);
    tick();
    tick();
    check("fitness_hold", int'(bus1.fitness), fit);
    check("perfect_hold", int'(bus1.perfect), perf);
    check("circ_inp_hold", int'(bus1.circ_inp), 3);
    check("busy_idle", int'(bus1.busy), 0);
  endtask

  task automatic run4(input logic [31:0] tgt, input int fit, input int perf);
    exp_t e;
    bus4.target_tt = tgt;
    bus4.start     = 1'b1;
    e.fit = fit; e.perf = perf; e.cyc = cyc_cnt + 16*W + 1;
    q4.push_back(e);
    tick();
    bus4.start = 1'b0;
    for (int k = 0; k < 16*W + 4; k++) tick();
    check("fitness4_hold", int'(bus4.fitness), fit);
    check("circ_inp4_hold", int'(bus4.circ_inp), 15);
  endtask

  initial begin
    rst_n = 1'b0;
    osc_mode = 1'b0;
    bus1.start = 1'b0;
    bus1.target_tt = '0;
    bus4.start = 1'b0;
    bus4.target_tt = '0;
    tick(); tick(); tick();
    check("rst_busy", int'(bus1.busy), 0);
    check("rst_done", int'(bus1.done), 0);
    check("rst_fitness", int'(bus1.fitness), 0);
    check("rst_perfect", int'(bus1.perfect), 0);
    check("rst_circ_inp", int'(bus1.circ_inp), 0);
    check("rst_fitness4", int'(bus4.fitness), 0);
    rst_n = 1'b1;
    tick();

    // XOR circuit against XOR target, then AND target.
    run1(4'b0110, 4, 1);
    run1(4'b1000, 1, 0);

    // Start re-pulsed during RUN (cycle 3) and FINISH (cycle 4W+1) must be ignored.
    begin
      exp_t e;
      bus1.target_tt = 4'b0110;
      bus1.start = 1'b1;
      e.fit = 4; e.perf = 1; e.cyc = cyc_cnt + 4*W + 1;
      q1.push_back(e);
      for (int k = 1; k <= 4*W + 6; k++) begin
        tick();
        bus1.start = (k == 3 || k == 4*W + 1);
        if (k > 4*W + 1) begin
          check("no_restart_busy", int'(bus1.busy), 0);
          check("no_restart_inp", int'(bus1.circ_inp), 3);
        end
      end
      bus1.start = 1'b0;
    end

    // Reset asserted at cycle 5 of a run abandons it; start in the first cycle after release.
    bus1.target_tt = 4'b0110;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrun_rst_busy", int'(bus1.busy), 0);
    check("midrun_rst_fitness", int'(bus1.fitness), 0);
    check("midrun_rst_perfect", int'(bus1.perfect), 0);
    check("midrun_rst_inp", int'(bus1.circ_inp), 0);
    check("midrun_rst_done", int'(bus1.done), 0);
    run1(4'b0110, 4, 1);

`ifdef GENETICO_OSC_CHECK_EN
    // Output toggling every cycle on vector 3 scores zero for that vector.
    osc_mode = 1'b1;
    run1(4'b0110, 3, 0);
    osc_mode = 1'b0;
`endif

    // Full-width accumulation: 32 matches must not wrap; all-zero target scores nothing.
    run4(32'hFFFF_FFFF, 32, 1);
    run4(32'h0000_0000, 0, 0);

    for (int k = 0; k < 5; k++) tick();
    check("q1_drained", q1.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
